eth_tx_axis_pkt_gen: RTL and testbench

//  Ethernet TX AXI-S traffic source: produces framed packets on the TX AXI-S master channel feeding the HSSI TX pipeline.

---
 rtl/eth_pkt_gen_pkg.sv | 38 +++
 rtl/eth_pkt_gen_prbs31.sv | 43 ++++
 rtl/eth_tx_axis_pkt_gen.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_axis_pkt_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_gen_pkg.sv
// Shared types and constants for the Ethernet TX AXI-S packet generator.
package eth_pkt_gen_pkg;

    // Default bus widths of the Ethernet TX channel.
    localparam int ETH_TDATA_WIDTH = 64;
    localparam int ETH_TUSER_WIDTH = 1;

    // Configuration field widths.
    localparam int LEN_W = 14;
    localparam int CNT_W = 32;
    localparam int IPG_W = 8;

    // PRBS-31 register value loaded on every start.
    localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } gen_state_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] num_pkts;
        logic [IPG_W-1:0] ipg;
    } gen_cfg_t;

    // Clamp a requested packet length into [lo, hi].
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int lo, input int hi);
        logic [LEN_W-1:0] res;
        res = len;
        if (32'(len) < 32'(lo)) res = LEN_W'(lo);
        else if (32'(len) > 32'(hi)) res = LEN_W'(hi);
        return res;
    endfunction

endpackage

// File: rtl/eth_pkt_gen_prbs31.sv
// Parallel PRBS-31 (x^31 + x^28 + 1) word generator.
// Produces N_WORDS successive 32-bit words per step; i_load restarts from the
// seed, i_adv moves the register past the words currently presented.
module eth_pkt_gen_prbs31
    import eth_pkt_gen_pkg::*;
#(
    parameter int N_WORDS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic                   i_adv,
    output logic [N_WORDS*32-1:0]  o_words
);

    logic [30:0]          r_lfsr;
    logic [30:0]          w_lfsr_nxt;
    logic [30:0]          w_v;
    logic                 w_fb;
    logic [N_WORDS*32-1:0] w_bits;

    // Unroll the LFSR for N_WORDS*32 steps; each step emits one output bit.
    always_comb begin
        w_v    = r_lfsr;
        w_fb   = 1'b0;
        w_bits = '0;
        for (int i = 0; i < N_WORDS*32; i++) begin
            w_fb      = w_v[30] ^ w_v[27];
            w_bits[i] = w_fb;
            w_v       = {w_v[29:0], w_fb};
        end
        w_lfsr_nxt = w_v;
    end

    // LFSR state: seed on reset/load, step on every accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) r_lfsr <= PRBS31_SEED;
        else if (i_adv)      r_lfsr <= w_lfsr_nxt;
    end

    assign o_words = w_bits;

endmodule

// File: rtl/eth_tx_axis_pkt_gen.sv
// Ethernet TX AXI-S traffic source for loopback/bring-up builds.
// Sends programmable-length packets with a deterministic payload so the RX
// checker can verify every byte. Define ETH_TX_PKT_GEN_PRBS_EN to replace the
// low 32 bits of every lane with a PRBS-31 stream.
module eth_tx_axis_pkt_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int TDATA_WIDTH = ETH_TDATA_WIDTH,
    parameter int TUSER_WIDTH = ETH_TUSER_WIDTH,
    parameter int LEN_MIN     = 64,
    parameter int LEN_MAX     = 9600
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic [LEN_W-1:0]         i_cfg_len,
    input  logic [CNT_W-1:0]         i_cfg_num_pkts,
    input  logic [IPG_W-1:0]         i_cfg_ipg,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_pkt_cnt,
    output logic                     o_m_tvalid,
    input  logic                     i_m_tready,
    output logic [TDATA_WIDTH-1:0]   o_m_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_m_tkeep,
    output logic                     o_m_tlast,
    output logic [TUSER_WIDTH-1:0]   o_m_tuser
);

    localparam int BYTES  = TDATA_WIDTH / 8;
    localparam int LANES  = TDATA_WIDTH / 64;
    localparam int BEAT_W = $clog2(LEN_MAX / BYTES + 1);

    gen_state_e        r_state, w_state_nxt;
    gen_cfg_t          r_cfg;
    logic [BEAT_W-1:0] r_beat;
    logic [IPG_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              r_stop_pend;

    logic [31:0]       w_len_u, w_beats_m1, w_rem;
    logic [BEAT_W-1:0] w_last_idx;
    logic [BYTES-1:0]  w_last_keep;
    logic              w_tvalid, w_start_acc, w_accept, w_last_beat, w_last_acc;
    logic              w_run_end, w_done;
    logic [LANES-1:0][31:0] w_lane_lo;
    logic [TDATA_WIDTH-1:0] w_tdata;

    // Packet geometry from the latched (already clamped) length.
    always_comb begin
        w_len_u    = 32'(r_cfg.len);
        w_beats_m1 = (w_len_u - 32'd1) / 32'(BYTES);
        w_rem      = w_len_u - w_beats_m1 * 32'(BYTES);
        w_last_idx = BEAT_W'(w_beats_m1);
        for (int i = 0; i < BYTES; i++) w_last_keep[i] = (32'(i) < w_rem);
    end

    assign w_tvalid    = (r_state == SEND);
    assign w_start_acc = (r_state == IDLE) && i_start;
    assign w_accept    = w_tvalid && i_m_tready;
    assign w_last_beat = (r_beat == w_last_idx);
    assign w_last_acc  = w_accept && w_last_beat;
    // A stop arriving on the final beat still ends the run there.
    assign w_run_end   = ((r_cfg.num_pkts != '0) && (r_pkt_cnt + CNT_W'(1) == r_cfg.num_pkts))
                         || r_stop_pend || i_stop;

    // Next-state and done-pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: if (i_start) w_state_nxt = SEND;
            SEND: begin
                if (w_last_acc) begin
                    if (w_run_end) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end else if (r_cfg.ipg != '0) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = SEND;
                    end
                end
            end
            GAP: begin
                if (r_stop_pend || i_stop) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else if (r_gap_cnt == IPG_W'(1)) begin
                    w_state_nxt = SEND;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_rst) w_done = 1'b0;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Config latch, beat/gap/packet counters and pending-stop flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg       <= '0;
            r_beat      <= '0;
            r_gap_cnt   <= '0;
            r_pkt_cnt   <= '0;
            r_stop_pend <= 1'b0;
        end else if (w_start_acc) begin
            r_cfg       <= '{len:      clamp_len(i_cfg_len, LEN_MIN, LEN_MAX),
                             num_pkts: i_cfg_num_pkts,
                             ipg:      i_cfg_ipg};
            r_beat      <= '0;
            r_pkt_cnt   <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            if (w_accept) r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            if (w_last_acc) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            if (w_last_acc)             r_gap_cnt <= r_cfg.ipg;
            else if (r_state == GAP)    r_gap_cnt <= r_gap_cnt - IPG_W'(1);
            if (w_state_nxt == IDLE)    r_stop_pend <= 1'b0;
            else if (i_stop)            r_stop_pend <= 1'b1;
        end
    end

`ifdef ETH_TX_PKT_GEN_PRBS_EN
    logic [LANES*32-1:0] w_prbs;

    eth_pkt_gen_prbs31 #(.N_WORDS(LANES)) u_prbs (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_start_acc),
        .i_adv   (w_accept),
        .o_words (w_prbs)
    );

    // Low lane word comes from successive PRBS words.
    always_comb begin
        for (int k = 0; k < LANES; k++) w_lane_lo[k] = w_prbs[k*32 +: 32];
    end
`else
    // Low lane word is the byte offset of the lane within the packet.
    always_comb begin
        for (int k = 0; k < LANES; k++)
            w_lane_lo[k] = 32'(r_beat) * 32'(BYTES) + 32'(k * 8);
    end
`endif

    // Lane assembly: {pkt_id, low word}; bus reads zero while not valid.
    always_comb begin
        w_tdata = '0;
        if (w_tvalid) begin
            for (int k = 0; k < LANES; k++) w_tdata[k*64 +: 64] = {r_pkt_cnt, w_lane_lo[k]};
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_done     = w_done;
    assign o_pkt_cnt  = r_pkt_cnt;
    assign o_m_tvalid = w_tvalid;
    assign o_m_tdata  = w_tdata;
    assign o_m_tlast  = w_tvalid && w_last_beat;
    assign o_m_tkeep  = !w_tvalid ? '0 : (w_last_beat ? w_last_keep : '1);
    assign o_m_tuser  = '0;

endmodule

// File: tb/tb_eth_tx_axis_pkt_gen.sv
// Directed, table-driven bench for eth_tx_axis_pkt_gen (64-bit bus, default build).
module tb_eth_tx_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [13:0] cfg_len = '0;
    logic [31:0] cfg_num = '0;
    logic [7:0]  cfg_ipg = '0;
    logic        busy, done;
    logic [31:0] pkt_cnt;
    logic        tvalid, tready = 1'b0, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [0:0]  tuser;

    eth_tx_axis_pkt_gen dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_stop         (stop),
        .i_cfg_len      (cfg_len),
        .i_cfg_num_pkts (cfg_num),
        .i_cfg_ipg      (cfg_ipg),
        .o_busy         (busy),
        .o_done         (done),
        .o_pkt_cnt      (pkt_cnt),
        .o_m_tvalid     (tvalid),
        .i_m_tready     (tready),
        .o_m_tdata      (tdata),
        .o_m_tkeep      (tkeep),
        .o_m_tlast      (tlast),
        .o_m_tuser      (tuser)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    typedef struct {
        logic [13:0] len;
        logic [31:0] num;
        logic [7:0]  ipg;
        int          rdy_pct;
        int          stop_at;    // loop cycle of a stop pulse, -1 none
        int          stb_at;     // loop cycle of a start-while-busy pulse, -1 none
        int          exp_beats;
        logic [7:0]  exp_keep;
        int          exp_pkts;
    } vec_t;

    vec_t vecs[8];

    // Start one run and follow it cycle by cycle until done, checking every beat.
    task automatic run_vec(input vec_t v, input string tag);
        int          cyc, beat, gap, pkts, done_cnt, first_v, err;
        logic [31:0] id;
        logic        in_pkt, after_pkt, prev_stall, done_seen, finished, last_b;
        logic [63:0] p_data, exp_d;
        logic [7:0]  p_keep;
        logic        p_last;
        cyc = 0; beat = 0; gap = 0; pkts = 0; done_cnt = 0; first_v = -1; err = 0;
        id = '0; in_pkt = 0; after_pkt = 0; prev_stall = 0; done_seen = 0; finished = 0;
        p_data = '0; p_keep = '0; p_last = 0;

        @(negedge clk);
        start = 1'b1; stop = 1'b0; tready = 1'b1;
        cfg_len = v.len; cfg_num = v.num; cfg_ipg = v.ipg;
        #1;
        check({tag, ".pre_valid"}, 64'(tvalid), 64'd0);

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            start = (cyc == v.stb_at);
            if (start) cfg_len = 14'd200;
            stop   = (cyc == v.stop_at);
            tready = ($urandom_range(0, 99) < v.rdy_pct);
            #1;
            if (done_seen) begin
                check({tag, ".busy_end"}, 64'(busy), 64'd0);
                check({tag, ".valid_end"}, 64'(tvalid), 64'd0);
                finished = 1;
            end else begin
                if (prev_stall && (!tvalid || tdata !== p_data || tkeep !== p_keep || tlast !== p_last))
                    err++;
                if (tvalid) begin
                    if (first_v < 0) begin
                        first_v = cyc;
                        check({tag, ".busy_run"}, 64'(busy), 64'd1);
                    end
                    if (!in_pkt && after_pkt) check({tag, ".gap"}, 64'(gap), 64'(v.ipg));
                    in_pkt = 1;
                    last_b = (beat == v.exp_beats - 1);
                    exp_d  = {id, 32'(beat * 8)};
                    if (tdata !== exp_d) err++;
                    if (tlast !== last_b) err++;
                    if (tkeep !== (last_b ? v.exp_keep : 8'hFF)) err++;
                    prev_stall = !tready;
                    p_data = tdata; p_keep = tkeep; p_last = tlast;
                    if (tready) begin
                        if (last_b) begin
                            check({tag, ".pkt"}, 64'(err), 64'd0);
                            err = 0; pkts++; id++; beat = 0;
                            in_pkt = 0; after_pkt = 1; gap = 0;
                        end else begin
                            beat++;
                        end
                    end
                end else begin
                    if (in_pkt) err++;
                    if (after_pkt) gap++;
                    prev_stall = 0;
                end
                if (done) begin
                    done_cnt++;
                    done_seen = 1;
                end
            end
            cyc++;
        end
        start = 1'b0; stop = 1'b0;
        check({tag, ".timeout"}, 64'(finished), 64'd1);
        check({tag, ".tail"}, 64'(err), 64'd0);
        check({tag, ".first_lat"}, 64'(first_v), 64'd0);
        check({tag, ".pkts"}, 64'(pkts), 64'(v.exp_pkts));
        check({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(v.exp_pkts));
        check({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          len       num    ipg   rdy  stop stb beats keep   pkts
        vecs[0] = '{14'd64,    32'd1, 8'd0, 100, -1, -1, 8,    8'hFF, 1};
        vecs[1] = '{14'd65,    32'd2, 8'd3, 100, -1, -1, 9,    8'h01, 2};
        vecs[2] = '{14'd100,   32'd4, 8'd0, 50,  -1, -1, 13,   8'h0F, 4};
        vecs[3] = '{14'd10,    32'd1, 8'd0, 100, -1, -1, 8,    8'hFF, 1};
        vecs[4] = '{14'd16000, 32'd1, 8'd0, 100, -1, -1, 1200, 8'hFF, 1};
        vecs[5] = '{14'd70,    32'd3, 8'd1, 100, -1, -1, 9,    8'h3F, 3};
        vecs[6] = '{14'd64,    32'd0, 8'd2, 100, 20, 3,  8,    8'hFF, 3};
        vecs[7] = '{14'd64,    32'd0, 8'd4, 100, 9,  -1, 8,    8'hFF, 1};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst.tvalid",  64'(tvalid),  64'd0);
        check("rst.busy",    64'(busy),    64'd0);
        check("rst.done",    64'(done),    64'd0);
        check("rst.pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst.tdata",   tdata,        64'd0);
        check("rst.tkeep",   64'(tkeep),   64'd0);
        check("rst.tlast",   64'(tlast),   64'd0);
        check("rst.tuser",   64'(tuser),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of the second packet of a run.
        @(negedge clk);
        start = 1'b1; cfg_len = 14'd64; cfg_num = 32'd5; cfg_ipg = 8'd0; tready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("midrst.pre_cnt",   64'(pkt_cnt), 64'd1);
        check("midrst.pre_valid", 64'(tvalid),  64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst.tvalid",  64'(tvalid),  64'd0);
        check("midrst.pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("midrst.busy",    64'(busy),    64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
